// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, run-time parity and stop-bit selection.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN (adds input i_break).
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PERIOD_W   = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic [PERIOD_W-1:0]  i_Period,
    input  logic [DATA_BITS-1:0] i_Byte,
    input  logic                 i_write_enable,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                 i_break,
`endif
    output logic                 o_UART_TX,
    output logic                 o_busy,
    output logic                 o_full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    state_t               state_q, state_d;
    logic [PERIOD_W-1:0]  cnt_q, cnt_d, period_q, period_d, period_in;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic [1:0]           par_q, par_d;
    logic                 two_q, two_d;
    logic                 tx_q, tx_d, busy_q, busy_d, full_q, full_d;
    logic                 push, pop, bit_done;
`ifdef UART_TX_BREAK_EN
    logic                 recov_q, recov_d;
`endif

    assign push      = i_write_enable && !full_q;
    assign period_in = (i_Period == '0) ? PERIOD_W'(1) : i_Period;
    assign bit_done  = (cnt_q == period_q - PERIOD_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        word_d   = word_q;
        period_d = period_q;
        par_d    = par_q;
        two_d    = two_q;
        pop      = 1'b0;
        tx_d     = 1'b1;
`ifdef UART_TX_BREAK_EN
        recov_d  = recov_q;
`endif
        // tx_d follows the current state, so the line lags the state register by one clock
        case (state_q)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (i_break) begin
                    tx_d    = 1'b0;
                    recov_d = 1'b1;
                    cnt_d   = '0;
                end else if (recov_q) begin
                    if (cnt_q >= period_in - PERIOD_W'(1)) begin
                        recov_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + PERIOD_W'(1);
                    end
                end else
`endif
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            DATA: begin
                tx_d = word_q[bit_q];
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (^par_q) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            PARITY: begin
                tx_d = (^word_q) ^ par_q[1];
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    cnt_d = '0;
                    if (two_q && bit_q == '0) begin
                        bit_d = BW'(1);
                    end else if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // a pop latches the frame configuration so mid-frame changes are ignored
        if (pop) begin
            word_d   = mem[rd_ptr_q];
            period_d = period_in;
            par_d    = i_parity_mode;
            two_d    = i_two_stop;
            cnt_d    = '0;
            bit_d    = '0;
            state_d  = START;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(FIFO_DEPTH));
        busy_d   = (state_d != IDLE) || (count_d != '0);
`ifdef UART_TX_BREAK_EN
        busy_d   = busy_d || i_break || recov_d;
`endif
    end

    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_Byte;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            period_q <= PERIOD_W'(1);
            par_q    <= '0;
            two_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            recov_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            period_q <= period_d;
            par_q    <= par_d;
            two_q    <= two_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
`ifdef UART_TX_BREAK_EN
            recov_q  <= recov_d;
`endif
        end
    end

    assign o_UART_TX = tx_q;
    assign o_busy    = busy_q;
    assign o_full    = full_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed, table-driven bench for uart_tx_fifo (default build, 8 data bits, depth 4).
module tb_uart_tx_fifo;
    localparam int DB = 8;
    localparam int PW = 20;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] period;
    logic [DB-1:0] data;
    logic          we;
    logic [1:0]    mode;
    logic          two;
    logic          tx, busy, full;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(DB), .PERIOD_W(PW), .FIFO_DEPTH(FD)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Period(period), .i_Byte(data),
        .i_write_enable(we), .i_parity_mode(mode), .i_two_stop(two),
        .o_UART_TX(tx), .o_busy(busy), .o_full(full)
    );

    typedef struct {
        int         per;
        logic [1:0] md;
        logic       ts;
        logic [7:0] dat;
        int         len;
        logic       par;
    } vec_t;

    vec_t       vecs [7];
    int         checks = 0;
    int         errors = 0;
    int         ns = 0;
    logic       exp_q [$];
    logic       cap_tx   [0:511];
    logic       cap_busy [0:511];
    logic       cap_full [0:511];
    logic [7:0] wbuf [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One sample per clock, taken on the falling edge; index i follows write edge N by i clocks.
    task automatic step();
        @(negedge clk);
        cap_tx[ns]   = tx;
        cap_busy[ns] = busy;
        cap_full[ns] = full;
        ns++;
    endtask

    task automatic write_seq(input int n);
        ns = 0;
        for (int i = 0; i < n; i++) begin
            data = wbuf[i];
            we   = 1'b1;
            step();
        end
        we = 1'b0;
    endtask

    task automatic add_frame(input logic [7:0] b, input int p, input logic [1:0] m, input logic t);
        int pe;
        pe = (p == 0) ? 1 : p;
        repeat (pe) exp_q.push_back(1'b0);
        for (int k = 0; k < DB; k++) repeat (pe) exp_q.push_back(b[k]);
        if (m == 2'b01 || m == 2'b10) repeat (pe) exp_q.push_back((^b) ^ (m == 2'b10));
        repeat (pe * (t ? 2 : 1)) exp_q.push_back(1'b1);
    endtask

    task automatic cmp_stream(input string name, input int start);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (cap_tx[start + i] !== exp_q[i]) bad++;
        chk(name, bad, 0);
    endtask

    initial begin
        vecs[0] = '{4, 2'b00, 1'b0, 8'h55, 40, 1'b0};
        vecs[1] = '{3, 2'b01, 1'b0, 8'h07, 33, 1'b1};
        vecs[2] = '{3, 2'b10, 1'b0, 8'h07, 33, 1'b0};
        vecs[3] = '{0, 2'b00, 1'b0, 8'hFF, 10, 1'b0};
        vecs[4] = '{2, 2'b11, 1'b1, 8'hA5, 22, 1'b0};
        vecs[5] = '{1, 2'b01, 1'b0, 8'h80, 11, 1'b1};
        vecs[6] = '{5, 2'b10, 1'b1, 8'h00, 60, 1'b1};

        rst = 1'b1; we = 1'b0; data = '0; period = PW'(4); mode = 2'b00; two = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_full", full, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            int pe;
            pe = (vecs[v].per == 0) ? 1 : vecs[v].per;
            period = PW'(vecs[v].per); mode = vecs[v].md; two = vecs[v].ts;
            wbuf[0] = vecs[v].dat;
            exp_q.delete();
            add_frame(vecs[v].dat, vecs[v].per, vecs[v].md, vecs[v].ts);
            write_seq(1);
            step();
            period = PW'(7); mode = ~mode; two = ~two;
            while (ns < vecs[v].len + 3) step();
            chk($sformatf("v%0d_idle_after_pop", v), cap_tx[1], 1);
            chk($sformatf("v%0d_start_low", v), cap_tx[2], 0);
            cmp_stream($sformatf("v%0d_frame_mismatches", v), 2);
            if (vecs[v].md == 2'b01 || vecs[v].md == 2'b10)
                chk($sformatf("v%0d_parity", v), cap_tx[2 + pe * 9 + pe / 2], vecs[v].par);
            chk($sformatf("v%0d_busy_last_stop", v), cap_busy[vecs[v].len], 1);
            chk($sformatf("v%0d_busy_done", v), cap_busy[vecs[v].len + 2], 0);
            chk($sformatf("v%0d_line_done", v), cap_tx[vecs[v].len + 2], 1);
            repeat (3) @(negedge clk);
        end

        // back-to-back frames, two stop bits, no idle gap
        period = PW'(2); mode = 2'b00; two = 1'b1;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        exp_q.delete();
        add_frame(8'hA5, 2, 2'b00, 1'b1);
        add_frame(8'h3C, 2, 2'b00, 1'b1);
        write_seq(2);
        while (ns < 48) step();
        cmp_stream("b2b_frames_mismatches", 2);
        chk("b2b_stop_end", cap_tx[23], 1);
        chk("b2b_second_start", cap_tx[24], 0);
        chk("b2b_busy_last", cap_busy[44], 1);
        chk("b2b_busy_done", cap_busy[46], 0);
        repeat (3) @(negedge clk);

        // overfill: six writes, the one arriving while full is dropped
        period = PW'(1); mode = 2'b00; two = 1'b0;
        for (int i = 0; i < 6; i++) wbuf[i] = 8'(8'h11 * (i + 1));
        exp_q.delete();
        for (int i = 0; i < 5; i++) add_frame(wbuf[i], 1, 2'b00, 1'b0);
        write_seq(6);
        while (ns < 82) step();
        chk("fill_full_n3", cap_full[3], 0);
        chk("fill_full_n4", cap_full[4], 1);
        chk("fill_full_n5", cap_full[5], 1);
        chk("fill_full_after_pop", cap_full[12], 0);
        cmp_stream("fill_frames_mismatches", 2);
        begin
            int lows;
            lows = 0;
            for (int i = 52; i < 82; i++) if (cap_tx[i] !== 1'b1) lows++;
            chk("fill_no_sixth_frame", lows, 0);
        end
        chk("fill_busy_done", cap_busy[81], 0);
        repeat (3) @(negedge clk);

        // reset during data bit 3 with two frames still queued
        period = PW'(4); mode = 2'b00; two = 1'b0;
        wbuf[0] = 8'h08; wbuf[1] = 8'h00; wbuf[2] = 8'h00;
        write_seq(3);
        while (ns < 19) step();
        chk("rst_pre_bit3", cap_tx[18], 1);
        chk("rst_pre_full", cap_full[18], 0);
        chk("rst_pre_busy", cap_busy[18], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_tx", cap_tx[19], 1);
        chk("rst_busy", cap_busy[19], 0);
        chk("rst_full", cap_full[19], 0);
        while (ns < 80) step();
        begin
            int act;
            act = 0;
            for (int i = 20; i < 80; i++) if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) act++;
            chk("rst_quiet_after", act, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
